// File: rtl/mips_pkg.sv
// Shared types and constants for the mips_cpu_bus memory-side blocks.
// Imported by the bus arbiter and its helpers.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        RESP,
        ACK
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_D
    } owner_t;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

endpackage

// File: rtl/mips_bus_wait_timer.sv
// Counts consecutive waitrequest cycles of one bus transaction.
// Raises a sticky flag when the limit is reached; a limit of 0 disables it.
module mips_bus_wait_timer #(
    parameter int unsigned TIMEOUT = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic waiting,
    output logic timed_out
);

    localparam logic [31:0] LIMIT = 32'(TIMEOUT);

    logic [31:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            timed_out <= 1'b0;
        end else if (start) begin
            cnt <= '0;
        end else if (waiting && (LIMIT != '0)) begin
            if (cnt != LIMIT) begin
                cnt <= cnt + 32'd1;
            end
            if ((cnt + 32'd1) >= LIMIT) begin
                timed_out <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mips_bus_arbiter.sv
// Shares the single Avalon-MM master between instruction fetch and data
// load/store; one transaction at a time, all outputs registered.
module mips_bus_arbiter #(
    parameter bit          ROUND_ROBIN  = 1'b0,
    parameter int unsigned TIMEOUT      = 0,
    parameter logic [31:0] RESET_VECTOR = mips_pkg::RESET_VECTOR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_write,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_byteenable,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        misaligned,
    output logic        bus_timeout,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata
);

    import mips_pkg::*;

    arb_state_t  state, state_nxt;
    owner_t      owner, owner_nxt;
    logic        rr_d_next, rr_nxt;
    logic [31:0] addr_nxt, wdata_nxt, if_rdata_nxt, d_rdata_nxt;
    logic [3:0]  be_nxt;
    logic        read_nxt, write_nxt;
    logic        if_ack_nxt, d_ack_nxt, mis_nxt;
    logic        grant_d, start_bus;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= OWN_IF;
            rr_d_next  <= 1'b1;
            address    <= RESET_VECTOR;
            read       <= 1'b0;
            write      <= 1'b0;
            writedata  <= '0;
            byteenable <= '0;
            if_ack     <= 1'b0;
            d_ack      <= 1'b0;
            misaligned <= 1'b0;
            if_rdata   <= '0;
            d_rdata    <= '0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            rr_d_next  <= rr_nxt;
            address    <= addr_nxt;
            read       <= read_nxt;
            write      <= write_nxt;
            writedata  <= wdata_nxt;
            byteenable <= be_nxt;
            if_ack     <= if_ack_nxt;
            d_ack      <= d_ack_nxt;
            misaligned <= mis_nxt;
            if_rdata   <= if_rdata_nxt;
            d_rdata    <= d_rdata_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        rr_nxt       = rr_d_next;
        addr_nxt     = address;
        read_nxt     = read;
        write_nxt    = write;
        wdata_nxt    = writedata;
        be_nxt       = byteenable;
        if_ack_nxt   = 1'b0;
        d_ack_nxt    = 1'b0;
        mis_nxt      = 1'b0;
        if_rdata_nxt = if_rdata;
        d_rdata_nxt  = d_rdata;
        grant_d      = 1'b0;
        start_bus    = 1'b0;
        unique case (state)
            IDLE: begin
                if (if_req || d_req) begin
                    // rr_d_next only matters when both ask at once
                    grant_d   = d_req && (!if_req || !ROUND_ROBIN || rr_d_next);
                    owner_nxt = grant_d ? OWN_D : OWN_IF;
                    rr_nxt    = !grant_d;
                    addr_nxt  = grant_d ? d_addr : if_addr;
                    wdata_nxt = grant_d ? d_wdata : '0;
                    be_nxt    = grant_d ? d_byteenable : 4'hF;
                    if (addr_nxt[1:0] != 2'b00) begin
                        state_nxt  = ACK;
                        mis_nxt    = 1'b1;
                        if_ack_nxt = !grant_d;
                        d_ack_nxt  = grant_d;
                    end else begin
                        state_nxt = BUS;
                        start_bus = 1'b1;
                        write_nxt = grant_d && d_write;
                        read_nxt  = !(grant_d && d_write);
                    end
                end
            end
            BUS: begin
                if (!waitrequest) begin
                    read_nxt  = 1'b0;
                    write_nxt = 1'b0;
                    if (read) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt  = ACK;
                        d_ack_nxt  = (owner == OWN_D);
                        if_ack_nxt = (owner == OWN_IF);
                    end
                end
            end
            RESP: begin
                state_nxt = ACK;
                if (owner == OWN_D) begin
                    d_rdata_nxt = readdata;
                    d_ack_nxt   = 1'b1;
                end else begin
                    if_rdata_nxt = readdata;
                    if_ack_nxt   = 1'b1;
                end
            end
            ACK: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    mips_bus_wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_wait_timer (
        .clk      (clk),
        .reset    (reset),
        .start    (start_bus),
        .waiting  ((state == BUS) && waitrequest),
        .timed_out(bus_timeout)
    );

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Bench for mips_bus_arbiter: fixed-priority and round-robin instances
// share stimulus; table vectors, corner sequences and random traffic.
module tb_mips_bus_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, if_req, d_req, d_write, waitrequest;
    logic [31:0] if_addr, d_addr, d_wdata, readdata;
    logic [3:0]  d_byteenable;

    logic        a_if_ack, a_d_ack, a_mis, a_to, a_read, a_write;
    logic [31:0] a_if_rdata, a_d_rdata, a_address, a_writedata;
    logic [3:0]  a_be;
    logic        b_if_ack, b_d_ack, b_mis, b_to, b_read, b_write;
    logic [31:0] b_if_rdata, b_d_rdata, b_address, b_writedata;
    logic [3:0]  b_be;

    // a: round robin, TIMEOUT=4
    mips_bus_arbiter #(.ROUND_ROBIN(1'b1), .TIMEOUT(4)) dut_a (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(a_if_ack), .if_rdata(a_if_rdata),
        .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_byteenable(d_byteenable), .d_ack(a_d_ack), .d_rdata(a_d_rdata),
        .misaligned(a_mis), .bus_timeout(a_to), .address(a_address),
        .read(a_read), .write(a_write), .waitrequest(waitrequest),
        .writedata(a_writedata), .byteenable(a_be), .readdata(readdata)
    );

    // b: fixed priority, no timeout
    mips_bus_arbiter #(.ROUND_ROBIN(1'b0), .TIMEOUT(0)) dut_b (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(b_if_ack), .if_rdata(b_if_rdata),
        .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_byteenable(d_byteenable), .d_ack(b_d_ack), .d_rdata(b_d_rdata),
        .misaligned(b_mis), .bus_timeout(b_to), .address(b_address),
        .read(b_read), .write(b_write), .waitrequest(waitrequest),
        .writedata(b_writedata), .byteenable(b_be), .readdata(readdata)
    );

    logic        sel;
    logic        m_if_ack, m_d_ack, m_mis, m_read, m_write;
    logic [31:0] m_if_rdata, m_d_rdata, m_address, m_writedata;
    logic [3:0]  m_be;

    always_comb begin
        m_if_ack    = sel ? a_if_ack    : b_if_ack;
        m_d_ack     = sel ? a_d_ack     : b_d_ack;
        m_mis       = sel ? a_mis       : b_mis;
        m_read      = sel ? a_read      : b_read;
        m_write     = sel ? a_write     : b_write;
        m_if_rdata  = sel ? a_if_rdata  : b_if_rdata;
        m_d_rdata   = sel ? a_d_rdata   : b_d_rdata;
        m_address   = sel ? a_address   : b_address;
        m_writedata = sel ? a_writedata : b_writedata;
        m_be        = sel ? a_be        : b_be;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h want %08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        d_req;
        logic        d_write;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [3:0]  d_be;
        int          waits;
        logic [31:0] rdata;
        logic        exp_d;
        logic        exp_mis;
        logic        exp_rd;
        int          exp_lat;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
    } vec_t;

    // model of the requesters' last returned words
    logic [31:0] mdl_if_rd, mdl_d_rd;

    task automatic do_reset();
        reset = 1'b1;
        if_req = 1'b0; d_req = 1'b0; d_write = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0; d_byteenable = '0;
        waitrequest = 1'b0; readdata = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        mdl_if_rd = '0;
        mdl_d_rd  = '0;
    endtask

    // entered and left #1 after a rising edge, selected DUT idle
    task automatic run_vec(input vec_t v, input string tag);
        int   bus_n, lat, waits_left;
        logic got_if, got_d, got_mis, acc_rd;
        if_req = v.if_req; if_addr = v.if_addr;
        d_req = v.d_req; d_write = v.d_write; d_addr = v.d_addr;
        d_wdata = v.d_wdata; d_byteenable = v.d_be;
        waitrequest = 1'b0; readdata = $urandom;
        @(negedge clk);
        chk({tag, " idle"}, {m_read, m_write, m_if_ack, m_d_ack, m_mis}, 32'd0);
        @(posedge clk); #1;
        if_req = 1'b0; d_req = 1'b0;
        if_addr = $urandom; d_addr = $urandom; d_wdata = $urandom;
        d_byteenable = 4'($urandom); d_write = 1'($urandom);
        waits_left = v.waits; bus_n = 0; lat = 0; acc_rd = 1'b0;
        got_if = 1'b0; got_d = 1'b0; got_mis = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            waitrequest = (waits_left > 0);
            readdata = acc_rd ? v.rdata : $urandom;
            acc_rd = 1'b0;
            @(negedge clk);
            if (m_read || m_write) begin
                bus_n++;
                chk({tag, " rw"}, {m_read, m_write}, v.exp_rd ? 32'd2 : 32'd1);
                chk({tag, " addr"}, m_address, v.exp_addr);
                chk({tag, " be"}, m_be, v.exp_be);
                if (!v.exp_rd) chk({tag, " wdata"}, m_writedata, v.d_wdata);
                if (waitrequest) waits_left--;
                else acc_rd = m_read;
            end
            if (m_if_ack || m_d_ack) begin
                lat = k; got_if = m_if_ack; got_d = m_d_ack; got_mis = m_mis;
                break;
            end
            @(posedge clk); #1;
        end
        waitrequest = 1'b0;
        chk({tag, " latency"}, lat, v.exp_lat);
        chk({tag, " acks"}, {got_if, got_d}, v.exp_d ? 32'd1 : 32'd2);
        chk({tag, " misaligned"}, got_mis, v.exp_mis);
        chk({tag, " bus cycles"}, bus_n, v.exp_mis ? 0 : v.waits + 1);
        if (!v.exp_mis && v.exp_rd) begin
            if (v.exp_d) mdl_d_rd = v.rdata;
            else mdl_if_rd = v.rdata;
        end
        chk({tag, " if_rdata"}, m_if_rdata, mdl_if_rd);
        chk({tag, " d_rdata"}, m_d_rdata, mdl_d_rd);
        @(posedge clk); #1;
    endtask

    vec_t tbl[8];
    int   ga[$], gb[$], ca[$];
    int   n_ack;
    logic last_d, mdl_to;

    initial begin
        tbl[0] = '{1'b1, 32'hBFC00000, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0,
                   0, 32'h24020005, 1'b0, 1'b0, 1'b1, 3, 32'hBFC00000, 4'hF};
        tbl[1] = '{1'b0, 32'h0, 1'b1, 1'b1, 32'h00001004, 32'hDEADBEEF, 4'b0011,
                   3, 32'h0, 1'b1, 1'b0, 1'b0, 5, 32'h00001004, 4'b0011};
        tbl[2] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h00000002, 32'h0, 4'hF,
                   0, 32'h0, 1'b1, 1'b1, 1'b1, 1, 32'h00000002, 4'hF};
        tbl[3] = '{1'b1, 32'h00000100, 1'b1, 1'b0, 32'h00002000, 32'h0, 4'hF,
                   0, 32'h11112222, 1'b1, 1'b0, 1'b1, 3, 32'h00002000, 4'hF};
        tbl[4] = '{1'b1, 32'h00000102, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0,
                   0, 32'h0, 1'b0, 1'b1, 1'b1, 1, 32'h00000102, 4'hF};
        tbl[5] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h00003000, 32'h0, 4'hC,
                   2, 32'hCAFEF00D, 1'b1, 1'b0, 1'b1, 5, 32'h00003000, 4'hC};
        tbl[6] = '{1'b1, 32'h00000104, 1'b1, 1'b1, 32'h00000040, 32'h12345678, 4'hF,
                   1, 32'h0, 1'b1, 1'b0, 1'b0, 3, 32'h00000040, 4'hF};
        tbl[7] = '{1'b1, 32'h00000108, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0,
                   4, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b1, 7, 32'h00000108, 4'hF};

        sel = 1'b0;
        do_reset();
        @(negedge clk);
        chk("reset rw/acks a", {a_read, a_write, a_if_ack, a_d_ack, a_mis, a_to}, 32'd0);
        chk("reset rw/acks b", {b_read, b_write, b_if_ack, b_d_ack, b_mis, b_to}, 32'd0);
        chk("reset address", a_address, 32'hBFC00000);
        chk("reset writedata", a_writedata, 32'd0);
        chk("reset byteenable", a_be, 32'd0);
        chk("reset rdata", {a_if_rdata ^ 32'h0, a_d_rdata ^ 32'h0} == 64'd0, 32'd1);
        @(posedge clk); #1;

        // table vectors on the fixed-priority instance
        for (int i = 0; i < 8; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

        // both held for four transactions
        do_reset();
        if_req = 1'b1; d_req = 1'b1; d_write = 1'b0;
        if_addr = 32'h00000400; d_addr = 32'h00000800;
        readdata = 32'h55AA55AA;
        ga.delete(); gb.delete(); ca.delete();
        for (int k = 0; k < 40 && (ga.size() < 4 || gb.size() < 4); k++) begin
            @(negedge clk);
            if (a_if_ack || a_d_ack) begin ga.push_back(int'(a_d_ack)); ca.push_back(k); end
            if (b_if_ack || b_d_ack) gb.push_back(int'(b_d_ack));
            @(posedge clk); #1;
        end
        if_req = 1'b0; d_req = 1'b0;
        chk("arb grants a count", ga.size(), 4);
        chk("arb grants b count", gb.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr grant %0d", i), (i < ga.size()) ? ga[i] : -1, (i % 2 == 0) ? 1 : 0);
            chk($sformatf("fixed grant %0d", i), (i < gb.size()) ? gb[i] : -1, 1);
            chk($sformatf("rr ack cycle %0d", i), (i < ca.size()) ? ca[i] : -1, 3 + 4 * i);
        end

        // waitrequest stuck high: timeout without abort
        do_reset();
        if_req = 1'b1; if_addr = 32'h00002000; waitrequest = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        if_req = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk($sformatf("to read w%0d", k), a_read, 1'b1);
            chk($sformatf("to flag w%0d", k), a_to, (k >= 5) ? 1'b1 : 1'b0);
            chk($sformatf("to off w%0d", k), b_to, 1'b0);
            @(posedge clk); #1;
        end
        waitrequest = 1'b0;
        n_ack = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (a_if_ack) n_ack++;
            @(posedge clk); #1;
        end
        chk("to completes", n_ack, 1);
        chk("to sticky", a_to, 1'b1);
        do_reset();
        chk("to cleared", a_to, 1'b0);

        // reset during the second bus cycle of a read
        sel = 1'b1;
        if_req = 1'b1; if_addr = 32'h00003000; waitrequest = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        if_req = 1'b0;
        @(negedge clk);
        chk("mid bus1 read", a_read, 1'b1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("mid bus2 read", a_read, 1'b1);
        @(posedge clk); #1;
        reset = 1'b0; waitrequest = 1'b0;
        mdl_if_rd = '0; mdl_d_rd = '0;
        @(negedge clk);
        chk("mid rst read", a_read, 1'b0);
        chk("mid rst address", a_address, 32'hBFC00000);
        n_ack = 0;
        for (int k = 0; k < 4; k++) begin
            if (a_if_ack || a_d_ack) n_ack++;
            @(posedge clk); #1;
            @(negedge clk);
        end
        chk("mid rst no ack", n_ack, 0);
        @(posedge clk); #1;
        run_vec('{1'b1, 32'h00003004, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0,
                  0, 32'h0BADC0DE, 1'b0, 1'b0, 1'b1, 3, 32'h00003004, 4'hF}, "after rst");

        // random traffic on the round-robin instance
        do_reset();
        sel = 1'b1;
        last_d = 1'b0;
        mdl_to = 1'b0;
        for (int t = 0; t < 60; t++) begin
            vec_t        v;
            logic        gd;
            logic [31:0] wa;
            v.if_req = 1'($urandom);
            v.d_req = 1'($urandom);
            if (!v.if_req && !v.d_req) v.d_req = 1'b1;
            v.if_addr = $urandom; v.d_addr = $urandom;
            v.if_addr[1:0] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            v.d_addr[1:0]  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            v.d_write = 1'($urandom);
            v.d_wdata = $urandom;
            v.d_be = 4'($urandom);
            v.waits = $urandom_range(0, 5);
            v.rdata = $urandom;
            // the requester not served last wins a tie
            if (v.if_req && v.d_req) gd = !last_d;
            else gd = v.d_req;
            last_d = gd;
            wa = gd ? v.d_addr : v.if_addr;
            v.exp_d = gd;
            v.exp_addr = wa;
            v.exp_mis = (wa % 4) != 0;
            v.exp_rd = !(gd && v.d_write);
            v.exp_be = gd ? v.d_be : 4'hF;
            v.exp_lat = v.exp_mis ? 1 : (v.exp_rd ? 3 : 2) + v.waits;
            if (!v.exp_mis && v.waits >= 4) mdl_to = 1'b1;
            run_vec(v, $sformatf("rnd%0d", t));
            chk($sformatf("rnd%0d timeout", t), a_to, mdl_to);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_bus_arbiter.md
Name: mips_bus_arbiter

Overview:
- Shares the CPU's single Avalon memory-mapped master port between two internal requesters: instruction fetch (read-only) and data load/store.
- Latches one request at a time, drives the bus, and holds `address`, `read`, `write`, `writedata` and `byteenable` stable while `waitrequest` is high.
- Captures `readdata` one cycle after read acceptance and returns a single-cycle acknowledge to the owning requester.
- Sits between the CPU control FSM and the top-level bus pins of mips_cpu_bus.

Parameters:
- ROUND_ROBIN, 0: 0 = fixed priority, data beats fetch; 1 = alternate grant when both request.
- TIMEOUT, 0: maximum consecutive `waitrequest` cycles before `bus_timeout`; 0 disables the check.
- RESET_VECTOR, 32'hBFC00000: reset value of the internal address register; a debug aid only.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active-high
- if_req  in  1  fetch request; sampled only in IDLE
- if_addr  in  32  fetch byte address, word-aligned
- if_ack  out  1  one-cycle pulse; `if_rdata` valid
- if_rdata  out  32  fetched instruction word
- d_req  in  1  data request; sampled only in IDLE
- d_write  in  1  1 = store, 0 = load
- d_addr  in  32  data byte address, word-aligned
- d_wdata  in  32  store data, pre-shifted to lanes
- d_byteenable  in  4  lane enables
- d_ack  out  1  one-cycle pulse: store accepted, or `d_rdata` valid
- d_rdata  out  32  raw loaded word
- misaligned  out  1  one-cycle pulse: latched address had [1:0] != 0; no bus cycle issued
- bus_timeout  out  1  sticky until reset
- address  out  32  Avalon address
- read  out  1  Avalon read
- write  out  1  Avalon write
- waitrequest  in  1  Avalon waitrequest
- writedata  out  32  Avalon writedata
- byteenable  out  4  Avalon byteenable
- readdata  in  32  Avalon readdata; valid the cycle after read accepted

Behaviour:
- Reset values:
  - State IDLE.
  - `read`, `write`, `if_ack`, `d_ack`, `misaligned`, `bus_timeout` = 0.
  - `address` = RESET_VECTOR; `writedata`, `byteenable`, `if_rdata`, `d_rdata` = 0.
  - Round-robin pointer = data-next.
- All outputs are registered.
- States:
  - IDLE: no bus activity.
  - BUS: `read` or `write` asserted.
  - RESP: capture `readdata`.
  - ACK: pulse ack, return to IDLE.
- IDLE:
  - Select a requester. Both requesting, ROUND_ROBIN=0: data wins. ROUND_ROBIN=1: the requester not granted last wins.
  - Latch owner, address, write flag, `wdata`, `byteenable`. Fetch always uses `byteenable` 4'hF and `read`.
  - Aligned address: go to BUS.
  - Misaligned address: go to ACK with `misaligned`=1 together with the owner's ack; rdata is unchanged.
- BUS:
  - `address`/`read`/`write`/`writedata`/`byteenable` are constant for every cycle spent in BUS.
  - `waitrequest`=1: stay.
  - `waitrequest`=0 with read: go to RESP, deassert `read`.
  - `waitrequest`=0 with write: go to ACK, deassert `write`.
- RESP: register `readdata` into the owner's rdata; go to ACK.
- ACK:
  - Owner's ack = 1 for exactly this cycle; go to IDLE.
  - A requester still holding req in the following IDLE cycle starts a new transaction.
- Latency with zero wait states, counted from the IDLE sample cycle N:
  - Read ack at N+3.
  - Write ack at N+2.
  - Misaligned ack at N+1.
  - Each wait cycle adds 1.
- Requester inputs may change after the IDLE sample cycle without effect.
- Timeout:
  - The counter is cleared on entry to BUS and increments each BUS cycle with `waitrequest`=1.
  - Reaching TIMEOUT sets `bus_timeout`. The transaction keeps waiting; there is no abort.
  - The counter saturates at TIMEOUT.
- Reset mid-transaction: `read`/`write` drop at the reset edge, no ack is issued, the pending request is discarded, and the state becomes IDLE.
- `read` and `write` are never both 1; neither ack is ever asserted for the non-owner.

Decomposition:
- Shared package mips_pkg holds:
  - `arb_state_t` (IDLE, BUS, RESP, ACK)
  - `owner_t` (OWN_IF, OWN_D)
  - RESET_VECTOR constant
- Optional sub-module mips_bus_wait_timer, holding the timeout counter with saturate and sticky flag. All other logic is inline.

Test Plan:
- Fetch only, `if_addr`=32'hBFC00000, `waitrequest`=0, `readdata`=32'h24020005 one cycle after accept:
  - `read`=1 for 1 cycle with `address` 32'hBFC00000 and `byteenable` 4'hF.
  - `if_ack` pulses at N+3 with `if_rdata`=32'h24020005.
- Store `d_addr`=32'h00001004, `d_wdata`=32'hDEADBEEF, `d_byteenable`=4'b0011, `waitrequest` high 3 cycles:
  - `write` is held 4 cycles with constant `address`/`writedata`/`byteenable`.
  - `d_ack` pulses at N+5; `if_ack` stays 0.
- `if_req` and `d_req` both held high for 4 transactions:
  - ROUND_ROBIN=0: grants D,D,D,D.
  - ROUND_ROBIN=1: grants D,IF,D,IF.
- Load at `d_addr`=32'h00000002 -> no `read`/`write`; `d_ack` and `misaligned` at N+1.
- TIMEOUT=4 with `waitrequest` stuck high for 10 cycles:
  - `bus_timeout` rises at the 4th wait cycle and stays 1.
  - `read` remains asserted.
- Reset asserted during the 2nd BUS cycle of a read:
  - Next cycle: `read`=0, `address`=32'hBFC00000, no ack, state IDLE.
  - A new fetch completes normally afterwards.
